// File: rtl/feature_packer.sv
// ----------------------------------------------------------------------------
// feature_packer
//   Serial-to-parallel front end for the SVM classifier. Accepts one signed
//   sample per cycle on a valid/ready stream and packs N of them into a flat
//   bus of signed 16-bit slots (slot i at bits [i*16 +: 16]). A completed
//   frame is presented with vec_valid and held until vec_ack.
//
//   Optional feature macro: FEAT_SAT_EN
//     defined   : samples saturate to [-32768, 32767] before packing
//     undefined : samples are truncated to their low 16 bits
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   s_valid        input sample valid
//   s_ready        packer can accept a sample (high only while filling)
//   s_data         signed input sample, IN_W bits
//   s_last         marks the final sample of a frame
//   features_flat  packed 16-bit features, slot 0 = first sample
//   vec_valid      features_flat holds a complete frame
//   vec_ack        consumer has taken the vector
//   count          samples accepted in the current frame (0..N)
//   frame_err      one-cycle pulse on a framing error
// ----------------------------------------------------------------------------
module feature_packer #(
   parameter int N    = 8100,
   parameter int IN_W = 20,
   localparam int CW  = $clog2(N + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [IN_W-1:0]   s_data,
   input  logic              s_last,
   output logic [N*16-1:0]   features_flat,
   output logic              vec_valid,
   input  logic              vec_ack,
   output logic [CW-1:0]     count,
   output logic              frame_err
);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [N*16-1:0]   flat_q,  flat_d;
   logic              frame_err_q, frame_err_d;
   logic [15:0]       conv_w;

   // Bits [IN_W-1:15] all equal means the sample already fits in 16 signed bits.
   logic              fits_w;
   assign fits_w = (&s_data[IN_W-1:15]) | ~(|s_data[IN_W-1:15]);

`ifdef FEAT_SAT_EN
   assign conv_w = fits_w ? s_data[15:0]
                          : (s_data[IN_W-1] ? 16'h8000 : 16'h7FFF);
`else
   // Truncation ignores the range check; keep it named as intentionally unused.
   logic unused_fits;
   assign unused_fits = fits_w;
   assign conv_w      = s_data[15:0];
`endif

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through this block infers a latch.
      state_d     = state_q;
      count_d     = count_q;
      flat_d      = flat_q;
      frame_err_d = 1'b0;

      unique case (state_q)
         FILL: begin
            if (s_valid) begin
               for (int i = 0; i < N; i++) begin
                  if (count_q == CW'(i)) flat_d[i*16 +: 16] = conv_w;
               end
               if (count_q == CW'(N - 1)) begin
                  // Frame is full regardless of s_last; a missing s_last is flagged.
                  state_d     = HOLD;
                  count_d     = CW'(N);
                  frame_err_d = ~s_last;
               end else if (s_last) begin
                  // Short frame: discard it, stale slots remain until overwritten.
                  count_d     = '0;
                  frame_err_d = 1'b1;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         HOLD: begin
            if (vec_ack) begin
               state_d = FILL;
               count_d = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         count_q     <= '0;
         flat_q      <= '0;
         frame_err_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         count_q     <= count_d;
         flat_q      <= flat_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign s_ready       = (state_q == FILL);
   assign vec_valid     = (state_q == HOLD);
   assign count         = count_q;
   assign features_flat = flat_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_feature_packer.sv
// ----------------------------------------------------------------------------
// tb_feature_packer
//   Directed self-checking bench for feature_packer with N=4, IN_W=20.
//   Inputs change 1 ns after a rising edge; outputs are sampled at the same
//   point, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_feature_packer;

   localparam int N    = 4;
   localparam int IN_W = 20;
   localparam int CW   = $clog2(N + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              s_valid;
   logic              s_ready;
   logic [IN_W-1:0]   s_data;
   logic              s_last;
   logic [N*16-1:0]   features_flat;
   logic              vec_valid;
   logic              vec_ack;
   logic [CW-1:0]     count;
   logic              frame_err;

   int n_cmp = 0;
   int n_err = 0;

   feature_packer #(.N(N), .IN_W(IN_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_last        (s_last),
      .features_flat (features_flat),
      .vec_valid     (vec_valid),
      .vec_ack       (vec_ack),
      .count         (count),
      .frame_err     (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transfer; caller guarantees s_ready is high.
   task automatic send(input int v, input logic last);
      s_valid = 1'b1;
      s_data  = IN_W'(v);
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic ack_once();
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
   endtask

   // Streaming model state
   logic [15:0] exp_slot [N];
   int          pos;

   // Streams with vec_ack held high until `frames` vectors have been seen.
   // rand_valid=0 drives s_valid constantly and checks a 5-cycle frame period.
   task automatic run_stream(input int frames, input bit rand_valid, input int budget,
                             inout int seq);
      int seen = 0;
      int cyc  = 0;
      int last_vv = -1;
      logic xfer, wrap;
      while (seen < frames && cyc < budget) begin
         s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data  = IN_W'(seq * 3 + 1);
         s_last  = (pos == N - 1);
         xfer    = s_valid & s_ready;
         tick();
         cyc++;
         wrap = 1'b0;
         if (xfer) begin
            exp_slot[pos] = 16'(seq * 3 + 1);
            seq++;
            if (pos == N - 1) begin pos = 0; wrap = 1'b1; end
            else pos++;
         end
         check("stream_vv_timing", 64'(vec_valid), 64'(wrap));
         if (wrap) begin
            seen++;
            check("stream_flat", features_flat,
                  {exp_slot[3], exp_slot[2], exp_slot[1], exp_slot[0]});
            check("stream_ferr", 64'(frame_err), 64'd0);
            if (!rand_valid) begin
               if (last_vv >= 0) check("stream_period", 64'(cyc - last_vv), 64'd5);
               last_vv = cyc;
            end
         end
      end
      if (seen < frames) check("stream_budget", 64'(seen), 64'(frames));
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      int seq;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      vec_ack = 1'b0;
      tick();
      tick();

      // Reset state (rst still high)
      check("rst_count",   64'(count),      64'd0);
      check("rst_flat",    features_flat,   64'd0);
      check("rst_vv",      64'(vec_valid),  64'd0);
      check("rst_ferr",    64'(frame_err),  64'd0);
      check("rst_sready",  64'(s_ready),    64'd1);
      rst = 1'b0;

      // 1. Basic frame, ack after three HOLD cycles
      for (int i = 0; i < N; i++) begin
         send(i + 1, i == N - 1);
         check("t1_vv",   64'(vec_valid), 64'(i == N - 1));
         check("t1_ferr", 64'(frame_err), 64'd0);
         check("t1_count", 64'(count), (i == N - 1) ? 64'd4 : 64'(i + 1));
      end
      check("t1_flat", features_flat, {16'd4, 16'd3, 16'd2, 16'd1});
      for (int h = 0; h < 3; h++) begin
         check("t1_sready_hold", 64'(s_ready), 64'd0);
         check("t1_flat_hold",   features_flat, {16'd4, 16'd3, 16'd2, 16'd1});
         check("t1_ferr_hold",   64'(frame_err), 64'd0);
         if (h < 2) tick();
      end
      ack_once();
      check("t1_vv_ack",    64'(vec_valid), 64'd0);
      check("t1_count_ack", 64'(count),     64'd0);
      check("t1_sready",    64'(s_ready),   64'd1);
      check("t1_flat_kept", features_flat,  {16'd4, 16'd3, 16'd2, 16'd1});

      // 2. Conversion of out-of-range samples
      send(20'h7FFFF, 1'b0);
      send(20'h80000, 1'b0);
`ifdef FEAT_SAT_EN
      check("t2_slot0", 64'(features_flat[15:0]),  64'h7FFF);
      check("t2_slot1", 64'(features_flat[31:16]), 64'h8000);
`else
      check("t2_slot0", 64'(features_flat[15:0]),  64'hFFFF);
      check("t2_slot1", 64'(features_flat[31:16]), 64'h0000);
`endif
      check("t2_count", 64'(count), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // 3. Short frame then a good frame (negative sample included)
      send(10, 1'b0);
      send(20, 1'b0);
      send(30, 1'b1);
      check("t3_ferr",  64'(frame_err), 64'd1);
      check("t3_count", 64'(count),     64'd0);
      check("t3_vv",    64'(vec_valid), 64'd0);
      check("t3_sready", 64'(s_ready),  64'd1);
      tick();
      check("t3_ferr_pulse", 64'(frame_err), 64'd0);
      send(5, 1'b0);
      send(-5, 1'b0);
      send(7, 1'b0);
      send(8, 1'b1);
      check("t3_vv2",   64'(vec_valid), 64'd1);
      check("t3_ferr2", 64'(frame_err), 64'd0);
      check("t3_flat",  features_flat, {16'd8, 16'd7, 16'hFFFB, 16'd5});
      ack_once();

      // 4. Full frame without s_last
      send(100, 1'b0);
      send(200, 1'b0);
      send(300, 1'b0);
      send(400, 1'b0);
      check("t4_vv",   64'(vec_valid), 64'd1);
      check("t4_ferr", 64'(frame_err), 64'd1);
      check("t4_flat", features_flat, {16'd400, 16'd300, 16'd200, 16'd100});
      tick();
      check("t4_ferr_pulse", 64'(frame_err), 64'd0);
      check("t4_vv_held",    64'(vec_valid), 64'd1);
      ack_once();

      // 5. Reset mid-frame
      send(50, 1'b0);
      send(60, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_count", 64'(count),     64'd0);
      check("t5_flat",  features_flat,  64'd0);
      check("t5_vv",    64'(vec_valid), 64'd0);
      for (int i = 0; i < N; i++) send(11 + i, i == N - 1);
      check("t5_flat2", features_flat, {16'd14, 16'd13, 16'd12, 16'd11});
      check("t5_vv2",   64'(vec_valid), 64'd1);
      ack_once();

      // 6. Back-to-back frames with vec_ack held high
      pos = 0;
      seq = 0;
      vec_ack = 1'b1;
      run_stream(5, 1'b1, 400, seq);
      run_stream(4, 1'b0, 100, seq);
      vec_ack = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
